// File: rtl/gcd_dispatch_if.sv
// -----------------------------------------------------------------------------
// gcd_dispatch_if -- signal bundle between the GCD dispatcher and its
// neighbours: the upstream operand source, the external gcd core and the
// downstream result sink.
//
//   in_valid / in_ready / in_opa / in_opb      upstream operand-pair handshake
//   gcd_opa / gcd_opb / gcd_start              request to the gcd core
//   gcd_result / gcd_done                      response from the gcd core
//   out_valid / out_ready / out_opa / out_opb / out_result
//                                              downstream result handshake
//   level                                      FIFO occupancy (0..DEPTH)
//
// Modport master is the dispatcher; slave is its environment.
// -----------------------------------------------------------------------------
interface gcd_dispatch_if #(
  parameter int DEPTH = 4,
  parameter int W     = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_opa;
  logic [W-1:0]  in_opb;
  logic [W-1:0]  gcd_opa;
  logic [W-1:0]  gcd_opb;
  logic          gcd_start;
  logic [W-1:0]  gcd_result;
  logic          gcd_done;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_opa;
  logic [W-1:0]  out_opb;
  logic [W-1:0]  out_result;
  logic [LW-1:0] level;

  modport master (
    input  in_valid, in_opa, in_opb, gcd_result, gcd_done, out_ready,
    output in_ready, gcd_opa, gcd_opb, gcd_start,
           out_valid, out_opa, out_opb, out_result, level
  );

  modport slave (
    output in_valid, in_opa, in_opb, gcd_result, gcd_done, out_ready,
    input  in_ready, gcd_opa, gcd_opb, gcd_start,
           out_valid, out_opa, out_opb, out_result, level
  );
endinterface

// File: rtl/gcd_dispatch.sv
// -----------------------------------------------------------------------------
// gcd_dispatch -- queues operand pairs in a small FIFO and feeds them one at a
// time to an external gcd core, delivering (opa, opb, gcd) in arrival order
// through a single output register.  Pairs with a zero operand bypass the core.
//
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     gcd_dispatch_if.master (upstream, gcd core and downstream signals)
// -----------------------------------------------------------------------------
module gcd_dispatch #(
  parameter int DEPTH = 4,   // power of two, 2..16
  parameter int W     = 32
) (
  input  logic           clk,
  input  logic           resetn,
  gcd_dispatch_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, RECOVER} state_t;

  state_t          r_state, w_next_state;
  logic [2*W-1:0]  r_mem [DEPTH];
  logic [LW-1:0]   r_wr_ptr, r_rd_ptr;
  logic            r_rst_done;
  logic [W-1:0]    r_gcd_opa, r_gcd_opb;
  logic            r_out_valid;
  logic [W-1:0]    r_out_opa, r_out_opb, r_out_result;

  logic [LW-1:0]   w_level;
  logic            w_empty, w_full, w_in_ready, w_push;
  logic [W-1:0]    w_head_a, w_head_b;
  logic            w_head_zero, w_out_free;
  logic            w_pop, w_launch, w_bypass, w_capture;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_empty     = (w_level == '0);
  assign w_full      = (w_level == LW'(DEPTH));
  // in_ready stays low until the first clock edge after reset is released.
  assign w_in_ready  = r_rst_done && !w_full;
  assign w_push      = bus.in_valid && w_in_ready;
  assign {w_head_a, w_head_b} = r_mem[r_rd_ptr[PW-1:0]];
  assign w_head_zero = (w_head_a == '0) || (w_head_b == '0);
  assign w_out_free  = !r_out_valid || bus.out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_launch     = 1'b0;
    w_bypass     = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        // gcd_done is deliberately not looked at here.
        if (!w_empty) begin
          if (w_head_zero) begin
            if (w_out_free) begin
              w_pop    = 1'b1;
              w_bypass = 1'b1;
            end
          end else begin
            w_pop        = 1'b1;
            w_launch     = 1'b1;
            w_next_state = RUN;
          end
        end
      end
      RUN: begin
        if (bus.gcd_done) begin
          if (w_out_free) begin
            w_capture    = 1'b1;
            w_next_state = RECOVER;
          end else begin
            w_next_state = HOLD;
          end
        end
      end
      HOLD: begin
        // The core keeps done/result up while gcd_start remains high.
        if (w_out_free) begin
          w_capture    = 1'b1;
          w_next_state = RECOVER;
        end
      end
      RECOVER: begin
        // Wait for the core to drop done so the next launch is a fresh one.
        if (!bus.gcd_done) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rst_done <= 1'b0;
      r_gcd_opa  <= '0;
      r_gcd_opb  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_rst_done <= 1'b1;
      if (w_push)   r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + LW'(1);
      if (w_launch) begin
        r_gcd_opa <= w_head_a;
        r_gcd_opb <= w_head_b;
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers alone define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= {bus.in_opa, bus.in_opb};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_out_opa    <= '0;
      r_out_opb    <= '0;
      r_out_result <= '0;
    end else if (w_bypass) begin
      r_out_valid  <= 1'b1;
      r_out_opa    <= w_head_a;
      r_out_opb    <= w_head_b;
      // (0,0) yields 0 because head_b is then zero as well.
      r_out_result <= (w_head_a == '0) ? w_head_b : w_head_a;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_opa    <= r_gcd_opa;
      r_out_opb    <= r_gcd_opb;
      r_out_result <= bus.gcd_result;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.level      = w_level;
  assign bus.gcd_opa    = r_gcd_opa;
  assign bus.gcd_opb    = r_gcd_opb;
  assign bus.gcd_start  = (r_state == RUN) || (r_state == HOLD);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_opa    = r_out_opa;
  assign bus.out_opb    = r_out_opb;
  assign bus.out_result = r_out_result;

endmodule
